// File: rtl/ddram_bram_responder.sv
// Block-RAM stand-in for the DDRAM burst port: bursty writes with byte enables, fixed-latency reads.
// Optional DDRAM_RESP_OOR_EN: beats above 2^ADDR_W words are dropped (writes) or read as zero.
module ddram_bram_responder #(
    parameter int ADDR_W = 14
) (
    input  logic        DDRAM_CLK,
    input  logic        reset_n,
    input  logic [7:0]  DDRAM_BURSTCNT,
    input  logic [28:0] DDRAM_ADDR,
    input  logic        DDRAM_RD,
    input  logic        DDRAM_WE,
    input  logic [63:0] DDRAM_DIN,
    input  logic [7:0]  DDRAM_BE,
    output logic        DDRAM_BUSY,
    output logic [63:0] DDRAM_DOUT,
    output logic        DDRAM_DOUT_READY
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_READ
    } state_e;

    state_e      state_q, state_d;
    logic [28:0] addr_q, addr_d;
    logic [7:0]  rem_q, rem_d;
    logic        busy_q, busy_d;
    logic        rdy_q, rdy_d;
    logic [63:0] dout_q;

    logic [7:0]        n_beats;
    logic              mem_we;
    logic              mem_re;
    logic              sel_new;
    logic              wr_en;
    logic              mem_oor;
    logic [ADDR_W-1:0] mem_idx;

    logic [63:0] mem [DEPTH];

    assign n_beats = (DDRAM_BURSTCNT == 8'd0) ? 8'd1 : DDRAM_BURSTCNT;

    // Command beats address with the bus; continuation beats use the counter
    assign mem_idx = sel_new ? DDRAM_ADDR[ADDR_W-1:0] : addr_q[ADDR_W-1:0];

`ifdef DDRAM_RESP_OOR_EN
    assign mem_oor = sel_new ? (|DDRAM_ADDR[28:ADDR_W]) : (|addr_q[28:ADDR_W]);
`else
    assign mem_oor = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        rdy_d   = 1'b0;
        mem_we  = 1'b0;
        mem_re  = 1'b0;
        sel_new = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (DDRAM_RD) begin
                    sel_new = 1'b1;
                    mem_re  = 1'b1;
                    rdy_d   = 1'b1;
                    addr_d  = DDRAM_ADDR + 29'd1;
                    rem_d   = n_beats - 8'd1;
                    state_d = S_READ;
                end else if (DDRAM_WE) begin
                    sel_new = 1'b1;
                    mem_we  = 1'b1;
                    addr_d  = DDRAM_ADDR + 29'd1;
                    rem_d   = n_beats - 8'd1;
                    if (n_beats > 8'd1) begin
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                if (DDRAM_WE) begin
                    mem_we = 1'b1;
                    addr_d = addr_q + 29'd1;
                    rem_d  = rem_q - 8'd1;
                    if (rem_q == 8'd1) begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_READ: begin
                if (rem_q != 8'd0) begin
                    mem_re = 1'b1;
                    rdy_d  = 1'b1;
                    addr_d = addr_q + 29'd1;
                    rem_d  = rem_q - 8'd1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d == S_READ);
    end

    // Writes are blocked while reset is held so an abort never touches memory
    assign wr_en = mem_we & ~mem_oor & reset_n;

    always_ff @(posedge DDRAM_CLK) begin
        if (wr_en) begin
            for (int i = 0; i < 8; i++) begin
                if (DDRAM_BE[i]) begin
                    mem[mem_idx][8*i +: 8] <= DDRAM_DIN[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge DDRAM_CLK or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            addr_q  <= 29'd0;
            rem_q   <= 8'd0;
            busy_q  <= 1'b0;
            rdy_q   <= 1'b0;
            dout_q  <= 64'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            busy_q  <= busy_d;
            rdy_q   <= rdy_d;
            if (mem_re) begin
                dout_q <= mem_oor ? 64'd0 : mem[mem_idx];
            end
        end
    end

    assign DDRAM_BUSY       = busy_q;
    assign DDRAM_DOUT       = dout_q;
    assign DDRAM_DOUT_READY = rdy_q;

endmodule

// File: doc/ddram_bram_responder.md
DDRAM_BRAM_RESPONDER -- requirements
Module: ddram_bram_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 14, meaning memory depth of 2^ADDR_W 64-bit words (128 KiB at default).
REQ-002 SHALL have port DDRAM_CLK, input, 1, the single clock; all logic on its rising edge.
REQ-003 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port DDRAM_BURSTCNT, input, 8, beats in burst, sampled on command acceptance.
REQ-005 SHALL have port DDRAM_ADDR, input, 29, 64-bit-word start address, sampled on command acceptance.
REQ-006 SHALL have port DDRAM_RD, input, 1, read command.
REQ-007 SHALL have port DDRAM_WE, input, 1, write beat valid.
REQ-008 SHALL have port DDRAM_DIN, input, 64, write data.
REQ-009 SHALL have port DDRAM_BE, input, 8, byte enables; bit i gates DIN[8i+7:8i].
REQ-010 SHALL have port DDRAM_BUSY, output, 1, registered wait-request; commands are accepted only in a cycle where it is low.
REQ-011 SHALL have port DDRAM_DOUT, output, 64, read data.
REQ-012 SHALL have port DDRAM_DOUT_READY, output, 1, DOUT valid strobe, one per read beat.

Function
REQ-013 SHALL implement states IDLE, WRITE, READ; storage is a synchronous single-port array of 2^ADDR_W x 64 bits.
REQ-014 SHALL, in IDLE, drive BUSY=0.
REQ-015 SHALL treat BURSTCNT=0 as 1.
REQ-016 SHALL, in IDLE with RD=1, accept a read: latch ADDR and N=BURSTCNT, enter READ, set BUSY=1 from the next cycle.
REQ-017 SHALL, for a read accepted at cycle T, assert DOUT_READY at cycles T+1..T+N with DOUT = mem[ADDR+k] at T+1+k, with no gaps.
REQ-018 SHALL deassert BUSY at T+N+1 and return to IDLE at that cycle.
REQ-019 SHALL, in IDLE with WE=1 and RD=0, write beat 0 to mem[ADDR] under BE in that cycle; if N>1 enter WRITE with N-1 beats remaining.
REQ-020 SHALL, in WRITE, keep BUSY=0 and write each cycle with WE=1 to the next sequential address; cycles with WE=0 stall without advancing.
REQ-021 SHALL return from WRITE to IDLE in the cycle after the last beat is written.
REQ-022 SHALL give RD priority when RD and WE are both high in IDLE; that WE beat is dropped.
REQ-023 SHALL ignore RD in WRITE and ignore WE and RD in READ.
REQ-024 SHALL compute burst addresses as ADDR+k in 29-bit arithmetic; memory index is the low ADDR_W bits.
REQ-025 SHALL keep DOUT_READY=0 and DOUT holding its last value outside read beats.

Reset
REQ-026 SHALL, on reset_n low, immediately force state IDLE, BUSY=0, DOUT_READY=0, DOUT=0, counters 0.
REQ-027 SHALL abort any burst in progress on reset without emitting further beats; memory contents are not cleared.
REQ-028 SHALL accept a new command in the first clock edge after reset_n deasserts.

Configuration
REQ-029 SHALL, with DDRAM_RESP_OOR_EN defined, treat any beat whose address has bits [28:ADDR_W] non-zero as out of range: the write is dropped; the read returns DOUT=0 with normal DOUT_READY timing.
REQ-030 SHALL, without DDRAM_RESP_OOR_EN, alias all addresses modulo 2^ADDR_W, with no range check logic.

Verification
REQ-031 SHALL cover: reset, WE=1 ADDR=0x10 BURSTCNT=4 DIN=0x1111..,0x2222..,0x3333..,0x4444.. BE=0xFF, then RD ADDR=0x10 BURSTCNT=4 -> DOUT_READY high 4 consecutive cycles starting 1 cycle after accept, DOUT sequence matches, BUSY low at accept+5.
REQ-032 SHALL cover: write 0xFFFF_FFFF_FFFF_FFFF to 0x20, then write 0 to 0x20 with BE=0x0F, read 0x20 -> DOUT=0xFFFF_FFFF_0000_0000.
REQ-033 SHALL cover: RD and WE high together in IDLE at ADDR=0x30 (previously 0xAA) with DIN=0x55 -> read returns 0xAA; a subsequent read of 0x30 also returns 0xAA.
REQ-034 SHALL cover: write burst BURSTCNT=3 with WE low one cycle between beats 1 and 2 -> all three words written to 0x40..0x42; BUSY stays 0.
REQ-035 SHALL cover: reset_n pulsed low at beat 2 of an 8-beat read -> DOUT_READY drops in the same cycle, no further beats, new RD accepted on the first edge after release.
REQ-036 SHALL cover (ADDR_W=14): write 0x1234 to ADDR=0x4005 then read 0x0005 -> 0x1234 without the macro; with DDRAM_RESP_OOR_EN the read of 0x0005 returns its prior value and a read of 0x4005 returns 0.
